// File: rtl/la_ioseq.sv
// IO ring power/enable sequencer: waits for a synchronized power-good, then ramps the
// ring enable lines up one at a time and ramps them down on stop. A power-good fault
// drops every line at once.
module la_ioseq #(
  parameter int RINGW   = 8,
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_fault,
  input  logic             pgood,
  input  logic [CNTW-1:0]  dly,
  output logic [RINGW-1:0] ioring,
  output logic             busy,
  output logic             ready,
  output logic             fault
);

  localparam int IDXW = (RINGW > 1) ? $clog2(RINGW) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RINGW - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_OFF, S_WAIT_PG, S_RAMPUP, S_ON, S_RAMPDN, S_FAULT
  } state_t;

  state_t           r_state, w_state_n;
  logic [CNTW-1:0]  r_cnt, w_cnt_n;
  logic [CNTW-1:0]  r_dly_q, w_dly_q_n;
  logic [IDXW-1:0]  r_idx, w_idx_n;
  logic [RINGW-1:0] w_ioring_n;
  logic             r_pg_meta, r_pg_s;
  logic             w_step;
  logic [RINGW-1:0] w_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pg_meta <= 1'b0;
      r_pg_s    <= 1'b0;
    end else begin
      r_pg_meta <= pgood;
      r_pg_s    <= r_pg_meta;
    end
  end

  assign w_step = (r_cnt == r_dly_q);
  assign w_mask = RINGW'(1) << r_idx;

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_dly_q_n  = r_dly_q;
    w_idx_n    = r_idx;
    w_ioring_n = ioring;
    case (r_state)
      S_OFF: begin
        w_ioring_n = '0;
        if (start && !stop) begin
          w_state_n = S_WAIT_PG;
          w_cnt_n   = '0;
        end
      end
      S_WAIT_PG: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_pg_s) begin
          w_state_n = S_RAMPUP;
          w_idx_n   = '0;
          w_cnt_n   = '0;
          w_dly_q_n = dly;
        end else if (stop) begin
          w_state_n = S_OFF;
        end else if (r_cnt == TO_LAST) begin
          w_state_n = S_FAULT;
        end
      end
      S_RAMPUP: begin
        if (!r_pg_s) begin
          w_state_n  = S_FAULT;
          w_ioring_n = '0;
        end else if (stop) begin
          // idx is the next bit to set, so the highest set bit is idx-1
          if (ioring == '0) begin
            w_state_n = S_OFF;
          end else begin
            w_state_n = S_RAMPDN;
            w_idx_n   = r_idx - 1'b1;
            w_cnt_n   = '0;
            w_dly_q_n = dly;
          end
        end else begin
          w_cnt_n = w_step ? '0 : r_cnt + 1'b1;
          if (w_step) begin
            w_ioring_n = ioring | w_mask;
            if (r_idx == IDX_LAST) w_state_n = S_ON;
            else                   w_idx_n   = r_idx + 1'b1;
          end
        end
      end
      S_ON: begin
        if (!r_pg_s) begin
          w_state_n  = S_FAULT;
          w_ioring_n = '0;
        end else if (stop) begin
          w_state_n = S_RAMPDN;
          w_idx_n   = IDX_LAST;
          w_cnt_n   = '0;
          w_dly_q_n = dly;
        end
      end
      S_RAMPDN: begin
        if (!r_pg_s) begin
          w_state_n  = S_FAULT;
          w_ioring_n = '0;
        end else begin
          w_cnt_n = w_step ? '0 : r_cnt + 1'b1;
          if (w_step) begin
            w_ioring_n = ioring & ~w_mask;
            if (r_idx == '0) w_state_n = S_OFF;
            else             w_idx_n   = r_idx - 1'b1;
          end
        end
      end
      S_FAULT: begin
        w_ioring_n = '0;
        if (clr_fault) w_state_n = S_OFF;
      end
      default: begin
        w_state_n  = S_OFF;
        w_ioring_n = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with ioring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_dly_q <= '0;
      r_idx   <= '0;
      ioring  <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_dly_q <= w_dly_q_n;
      r_idx   <= w_idx_n;
      ioring  <= w_ioring_n;
      busy    <= (w_state_n == S_WAIT_PG) || (w_state_n == S_RAMPUP) ||
                 (w_state_n == S_RAMPDN);
      ready   <= (w_state_n == S_ON);
      fault   <= (w_state_n == S_FAULT);
    end
  end

endmodule
